// File: rtl/md5_guess_dispatcher_pkg.sv
// md5_guess_dispatcher_pkg
//   Shared definitions for the md5 guess dispatcher: FSM state encoding,
//   candidate width, ASCII message width and the BCD -> ASCII helper.
//   No ports (package).
package md5_guess_dispatcher_pkg;

    localparam int         DIGITS   = 8;
    localparam int         BCD_W    = 4 * DIGITS;
    localparam int         MSG_W    = 64;
    localparam logic [3:0] ASCII_HI = 4'h3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Each digit d becomes byte {3, d}; the most significant digit lands in
    // the top byte so it is the first character of the message.
    function automatic logic [MSG_W-1:0] bcd_to_ascii(input logic [BCD_W-1:0] bcd);
        logic [MSG_W-1:0] msg;
        msg = '0;
        for (int i = 0; i < DIGITS; i++) begin
            msg[8*i +: 8] = {ASCII_HI, bcd[4*i +: 4]};
        end
        return msg;
    endfunction

endpackage

// File: rtl/md5_guess_dispatcher_bcd8_inc.sv
// bcd8_inc
//   Combinational 8-digit packed-BCD increment by one.
//   Ports:
//     bcd_i   [31:0]  current value, packed BCD
//     bcd_o   [31:0]  value + 1, packed BCD (wraps to 0 on overflow)
//     carry_o         carry out of the most significant digit
module bcd8_inc
    import md5_guess_dispatcher_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             carry_o
);

    // Ripple the +1 from the least significant digit; a 9 rolls to 0 and
    // keeps the carry alive, anything else absorbs it.
    always_comb begin
        bcd_o   = bcd_i;
        carry_o = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry_o) begin
                if (bcd_i[4*i +: 4] == 4'd9) begin
                    bcd_o[4*i +: 4] = 4'd0;
                end else begin
                    bcd_o[4*i +: 4] = bcd_i[4*i +: 4] + 4'd1;
                    carry_o         = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/md5_guess_dispatcher.sv
// md5_guess_dispatcher
//   Sweeps 8-digit decimal password candidates from START_BCD to 99999999
//   and hands each one, as an 8-byte ASCII message, to the lowest-index idle
//   md5 lane. Halts on a found pulse or when the range is exhausted.
//   Optional feature macro: DISPATCH_PAUSE_EN adds pause_i, which freezes
//   issuing and cur_bcd_o while in S_RUN.
//   Ports:
//     clk_i          system clock
//     rst_i          synchronous active-high reset
//     start_i        pulse: begin / restart the sweep from START_BCD
//     found_i        pulse: halt the sweep
//     pause_i        (DISPATCH_PAUSE_EN only) hold issuing while high
//     lane_ready_i   per-lane idle indication
//     lane_valid_o   per-lane one-cycle issue strobe
//     lane_msg_o     per-lane ASCII message, lane i at [64*i +: 64]
//     cur_bcd_o      next candidate to be issued, packed BCD
//     busy_o         high in S_RUN
//     done_o         high in S_DONE
//
//   state  | meaning
//   S_IDLE | after reset, waiting for start
//   S_RUN  | issuing one candidate per cycle to the first ready lane
//   S_HALT | stopped by found; start restarts from START_BCD
//   S_DONE | 99999999 issued; start restarts from START_BCD
module md5_guess_dispatcher
    import md5_guess_dispatcher_pkg::*;
#(
    parameter int          NUM_LANES = 2,
    parameter logic [31:0] START_BCD = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       found_i,
`ifdef DISPATCH_PAUSE_EN
    input  logic                       pause_i,
`endif
    input  logic [NUM_LANES-1:0]       lane_ready_i,
    output logic [NUM_LANES-1:0]       lane_valid_o,
    output logic [MSG_W*NUM_LANES-1:0] lane_msg_o,
    output logic [BCD_W-1:0]           cur_bcd_o,
    output logic                       busy_o,
    output logic                       done_o
);

    state_e                     state_q, state_d;
    logic [BCD_W-1:0]           cur_bcd_q, cur_bcd_d;
    logic [NUM_LANES-1:0]       lane_valid_q, lane_valid_d;
    logic [MSG_W*NUM_LANES-1:0] lane_msg_q, lane_msg_d;

    logic [BCD_W-1:0]           bcd_next;
    logic                       bcd_carry;
    logic [NUM_LANES-1:0]       grant;
    logic [MSG_W-1:0]           msg_ascii;
    logic                       issue_en;
    logic                       issue;

`ifdef DISPATCH_PAUSE_EN
    assign issue_en = ~pause_i;
`else
    assign issue_en = 1'b1;
`endif

    bcd8_inc u_bcd8_inc (
        .bcd_i   (cur_bcd_q),
        .bcd_o   (bcd_next),
        .carry_o (bcd_carry)
    );

    // Lowest-index ready lane wins: a lane is granted only if no lower lane
    // is ready.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_pick
        if (g == 0) begin : g_first
            assign grant[g] = lane_ready_i[0];
        end else begin : g_rest
            assign grant[g] = lane_ready_i[g] & ~(|lane_ready_i[g-1:0]);
        end
    end

    assign msg_ascii = bcd_to_ascii(cur_bcd_q);

    // found has priority over any ready lane in the same cycle.
    assign issue = (state_q == S_RUN) && !found_i && issue_en && (|lane_ready_i);

    always_comb begin
        state_d      = state_q;
        cur_bcd_d    = cur_bcd_q;
        lane_valid_d = '0;
        lane_msg_d   = lane_msg_q;

        case (state_q)
            S_IDLE, S_HALT, S_DONE: begin
                if (start_i && !found_i) begin
                    state_d   = S_RUN;
                    cur_bcd_d = START_BCD;
                end
            end

            S_RUN: begin
                if (found_i) begin
                    state_d = S_HALT;
                end else if (issue) begin
                    lane_valid_d = grant;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (grant[i]) begin
                            lane_msg_d[MSG_W*i +: MSG_W] = msg_ascii;
                        end
                    end
                    // Carry out means 99999999 just went out: hold it on
                    // the display rather than wrapping to zero.
                    if (bcd_carry) begin
                        state_d = S_DONE;
                    end else begin
                        cur_bcd_d = bcd_next;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cur_bcd_q    <= START_BCD;
            lane_valid_q <= '0;
            lane_msg_q   <= '0;
        end else begin
            state_q      <= state_d;
            cur_bcd_q    <= cur_bcd_d;
            lane_valid_q <= lane_valid_d;
            lane_msg_q   <= lane_msg_d;
        end
    end

    assign lane_valid_o = lane_valid_q;
    assign lane_msg_o   = lane_msg_q;
    assign cur_bcd_o    = cur_bcd_q;
    assign busy_o       = (state_q == S_RUN);
    assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_md5_guess_dispatcher.sv
// tb_md5_guess_dispatcher
//   Directed bench for md5_guess_dispatcher. Three instances with different
//   START_BCD values share clock and reset: u0 (0), u1 (99999998) and
//   u2 (00999999). Optional DISPATCH_PAUSE_EN build also exercises pause.
module tb_md5_guess_dispatcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         s0, f0, s1, f1, s2, f2;
    logic [1:0]   r0, v0, r1, v1, r2, v2;
    logic [127:0] m0, m1, m2;
    logic [31:0]  c0, c1, c2;
    logic         b0, d0, b1, d1, b2, d2;
`ifdef DISPATCH_PAUSE_EN
    logic         p0, p1, p2;
`endif

    int errors = 0;
    int checks = 0;
    int nstrobe;

    md5_guess_dispatcher #(.NUM_LANES(2), .START_BCD(32'h0000_0000)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(s0), .found_i(f0),
`ifdef DISPATCH_PAUSE_EN
        .pause_i(p0),
`endif
        .lane_ready_i(r0), .lane_valid_o(v0), .lane_msg_o(m0),
        .cur_bcd_o(c0), .busy_o(b0), .done_o(d0)
    );

    md5_guess_dispatcher #(.NUM_LANES(2), .START_BCD(32'h9999_9998)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(s1), .found_i(f1),
`ifdef DISPATCH_PAUSE_EN
        .pause_i(p1),
`endif
        .lane_ready_i(r1), .lane_valid_o(v1), .lane_msg_o(m1),
        .cur_bcd_o(c1), .busy_o(b1), .done_o(d1)
    );

    md5_guess_dispatcher #(.NUM_LANES(2), .START_BCD(32'h0099_9999)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(s2), .found_i(f2),
`ifdef DISPATCH_PAUSE_EN
        .pause_i(p2),
`endif
        .lane_ready_i(r2), .lane_valid_o(v2), .lane_msg_o(m2),
        .cur_bcd_o(c2), .busy_o(b2), .done_o(d2)
    );

    typedef struct {
        logic        start;
        logic        found;
        logic [1:0]  ready;
        logic [1:0]  valid;
        logic [63:0] msg0;
        logic [63:0] msg1;
        logic [31:0] cur;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // start, found, ready | valid, msg0, msg1, cur, busy, done  (u0, START 0)
        tbl[0]  = '{1'b1, 1'b0, 2'b01, 2'b00, 64'h0,      64'h0,      32'h0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 2'b01, 2'b01, "00000000", 64'h0,      32'h1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'b01, 2'b01, "00000001", 64'h0,      32'h2, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'b11, 2'b01, "00000002", 64'h0,      32'h3, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 2'b11, 2'b01, "00000003", 64'h0,      32'h4, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 2'b10, 2'b10, "00000003", "00000004", 32'h5, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 2'b00, 2'b00, "00000003", "00000004", 32'h5, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 2'b00, 2'b00, "00000003", "00000004", 32'h5, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'b01, 2'b00, "00000003", "00000004", 32'h5, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 2'b01, 2'b00, "00000003", "00000004", 32'h5, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 2'b01, 2'b00, "00000003", "00000004", 32'h5, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 2'b01, 2'b00, "00000003", "00000004", 32'h0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 2'b01, 2'b01, "00000000", "00000004", 32'h1, 1'b1, 1'b0};

        rst = 1'b1;
        s0 = 0; f0 = 0; r0 = 0;
        s1 = 0; f1 = 0; r1 = 0;
        s2 = 0; f2 = 0; r2 = 0;
`ifdef DISPATCH_PAUSE_EN
        p0 = 0; p1 = 0; p2 = 0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid", 128'(v0), 128'(2'b00));
        chk("reset_msg",   m0, 128'h0);
        chk("reset_cur",   128'(c0), 128'(32'h0));
        chk("reset_busy",  128'(b0), 128'(1'b0));
        chk("reset_done",  128'(d0), 128'(1'b0));
        chk("reset_cur_u1", 128'(c1), 128'(32'h9999_9998));
        chk("reset_cur_u2", 128'(c2), 128'(32'h0099_9999));
        rst = 1'b0;

        // Priority, handshake, found/start interactions on u0.
        for (int k = 0; k < 13; k++) begin
            s0 = tbl[k].start;
            f0 = tbl[k].found;
            r0 = tbl[k].ready;
            tick();
            chk($sformatf("vec%0d_valid", k), 128'(v0), 128'(tbl[k].valid));
            chk($sformatf("vec%0d_msg0", k),  128'(m0[63:0]), 128'(tbl[k].msg0));
            chk($sformatf("vec%0d_msg1", k),  128'(m0[127:64]), 128'(tbl[k].msg1));
            chk($sformatf("vec%0d_cur", k),   128'(c0), 128'(tbl[k].cur));
            chk($sformatf("vec%0d_busy", k),  128'(b0), 128'(tbl[k].busy));
            chk($sformatf("vec%0d_done", k),  128'(d0), 128'(tbl[k].done));
            @(negedge clk);
        end
        s0 = 0; f0 = 0;

        // Continuous ready: one strobe per clock, then the 19 -> 20 carry.
        r0 = 2'b01;
        nstrobe = 0;
        for (int k = 0; k < 18; k++) begin
            tick();
            if (v0 == 2'b01) nstrobe++;
            @(negedge clk);
        end
        chk("stream_strobes", 128'(nstrobe), 128'(18));
        chk("stream_cur19",   128'(c0), 128'(32'h0000_0019));
        chk("stream_msg18",   128'(m0[63:0]), 128'("00000018"));
        tick();
        chk("carry_msg19", 128'(m0[63:0]), 128'("00000019"));
        chk("carry_cur20", 128'(c0), 128'(32'h0000_0020));
        @(negedge clk);
        tick();
        chk("carry_msg20", 128'(m0[63:0]), 128'("00000020"));
        chk("carry_cur21", 128'(c0), 128'(32'h0000_0021));
        @(negedge clk);
        r0 = 2'b00;

        // End of range on u1.
        s1 = 1'b1;
        tick();
        chk("end_busy0", 128'(b1), 128'(1'b1));
        @(negedge clk);
        s1 = 1'b0; r1 = 2'b01;
        tick();
        chk("end_valid1", 128'(v1), 128'(2'b01));
        chk("end_msg1",   128'(m1[63:0]), 128'("99999998"));
        chk("end_cur1",   128'(c1), 128'(32'h9999_9999));
        chk("end_done1",  128'(d1), 128'(1'b0));
        @(negedge clk);
        tick();
        chk("end_valid2", 128'(v1), 128'(2'b01));
        chk("end_msg2",   128'(m1[63:0]), 128'("99999999"));
        chk("end_cur2",   128'(c1), 128'(32'h9999_9999));
        chk("end_done2",  128'(d1), 128'(1'b1));
        chk("end_busy2",  128'(b1), 128'(1'b0));
        @(negedge clk);
        tick();
        chk("end_valid3", 128'(v1), 128'(2'b00));
        chk("end_cur3",   128'(c1), 128'(32'h9999_9999));
        chk("end_done3",  128'(d1), 128'(1'b1));
        @(negedge clk);
        r1 = 2'b00; s1 = 1'b1;
        tick();
        chk("restart_busy", 128'(b1), 128'(1'b1));
        chk("restart_done", 128'(d1), 128'(1'b0));
        chk("restart_cur",  128'(c1), 128'(32'h9999_9998));
        @(negedge clk);
        s1 = 1'b0;

        // Multi-digit carry on u2, issued to lane 1.
        s2 = 1'b1;
        tick();
        @(negedge clk);
        s2 = 1'b0; r2 = 2'b10;
        tick();
        chk("mcarry_valid1", 128'(v2), 128'(2'b10));
        chk("mcarry_msg1",   128'(m2[127:64]), 128'("00999999"));
        chk("mcarry_cur1",   128'(c2), 128'(32'h0100_0000));
        @(negedge clk);
        tick();
        chk("mcarry_msg2",   128'(m2[127:64]), 128'("01000000"));
        chk("mcarry_cur2",   128'(c2), 128'(32'h0100_0001));
        chk("mcarry_lane0",  128'(m2[63:0]), 128'h0);
        chk("mcarry_busy",   128'({b2, d2}), 128'(2'b10));
        @(negedge clk);
        r2 = 2'b00;

`ifdef DISPATCH_PAUSE_EN
        // u0 is in S_RUN holding 00000021.
        p0 = 1'b1; r0 = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("pause%0d_valid", k), 128'(v0), 128'(2'b00));
            chk($sformatf("pause%0d_cur", k),   128'(c0), 128'(32'h0000_0021));
            @(negedge clk);
        end
        p0 = 1'b0;
        tick();
        chk("unpause_valid", 128'(v0), 128'(2'b01));
        chk("unpause_msg",   128'(m0[63:0]), 128'("00000021"));
        @(negedge clk);
        r0 = 2'b00;
`endif

        // Reset in the middle of a sweep.
        r0 = 2'b01;
        tick();
        chk("pre_rst_valid", 128'(v0), 128'(2'b01));
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst_valid", 128'(v0), 128'(2'b00));
        chk("rst_msg",   m0, 128'h0);
        chk("rst_cur",   128'(c0), 128'(32'h0));
        chk("rst_flags", 128'({b0, d0}), 128'(2'b00));
        chk("rst_cur_u1", 128'(c1), 128'(32'h9999_9998));
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_valid", 128'(v0), 128'(2'b00));
        chk("post_rst_busy",  128'(b0), 128'(1'b0));
        @(negedge clk);
        r0 = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
